// File: rtl/load_unit.sv
// load_unit: single-outstanding load pipeline between a core request port and
// an AXI-lite-style read channel. Fetches the aligned word that holds the
// requested byte/half/word, selects the lane, extends it and returns it on a
// response handshake.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_addr, req_funct3        byte address, load type (LB/LH/LW/LBU/LHU)
//   mem_arvalid/mem_arready     read-address handshake, mem_araddr word-aligned
//   mem_rvalid/mem_rready       read-data handshake, mem_rdata, mem_rerr
//   rsp_valid/rsp_ready         result handshake, rsp_data, rsp_err
//
// Build option:
//   LOAD_MISALIGN_TRAP_EN  when defined, misaligned LH/LHU/LW are answered with
//                          rsp_err=1 and no memory transaction is issued.

module load_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [31:0] mem_araddr,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rerr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e      state_q, state_d;
    word_t       addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    word_t       rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic        legal;
    logic        misaligned;
    logic        bad_req;

    // Lane select plus sign/zero extension of the returned word.
    function automatic word_t load_extend(input logic [2:0] f3, input logic [1:0] a,
                                          input word_t w);
        logic [7:0]  b;
        logic [15:0] h;
        word_t       r;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'b0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'b0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
`ifdef LOAD_MISALIGN_TRAP_EN
        misaligned = (((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) && req_addr[0]) ||
                     ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        bad_req = !legal || misaligned;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid) state_d = bad_req ? StResp : StAddr;
            StAddr:  if (mem_arready) state_d = StData;
            StData:  if (mem_rvalid) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            funct3_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    funct3_d   = req_funct3;
                    // Rejected requests skip memory; the response is prepared here.
                    rsp_data_d = '0;
                    rsp_err_d  = bad_req;
                end
            end
            StData: begin
                if (mem_rvalid) begin
                    rsp_err_d  = mem_rerr;
                    rsp_data_d = mem_rerr ? '0 : load_extend(funct3_q, addr_q[1:0], mem_rdata);
                end
            end
            default: ;
        endcase
    end

    // Outputs; req_ready is masked during reset so every output reads 0.
    always_comb begin
        req_ready   = (state_q == StIdle) && !rst;
        mem_arvalid = (state_q == StAddr);
        mem_araddr  = {addr_q[31:2], 2'b00};
        mem_rready  = (state_q == StData);
        rsp_valid   = (state_q == StResp);
        rsp_data    = rsp_data_q;
        rsp_err     = rsp_err_q;
    end

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic        mem_rerr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .mem_arvalid(mem_arvalid),
        .mem_arready(mem_arready),
        .mem_araddr (mem_araddr),
        .mem_rvalid (mem_rvalid),
        .mem_rready (mem_rready),
        .mem_rdata  (mem_rdata),
        .mem_rerr   (mem_rerr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        rerr;
        logic [31:0] exp_data;
        logic        exp_err;
        bit          exp_mem;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: what a load of this type should return, from the ISA rules.
    function automatic void ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] rdata, input logic rerr,
                                     output logic [31:0] data, output logic err,
                                     output bit mem);
        logic [31:0] b;
        logic [31:0] h;
        bit legal;
        bit mis;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        mis = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
        if (((f3 == 3'd1) || (f3 == 3'd5)) && (addr % 2 != 0)) mis = 1'b1;
        if ((f3 == 3'd2) && (addr % 4 != 0)) mis = 1'b1;
`endif
        mem = legal && !mis;
        b = (rdata >> (8 * (addr % 4))) & 32'hFF;
        h = (rdata >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        if (!mem || rerr) begin
            data = 32'h0;
            err  = 1'b1;
            return;
        end
        err = 1'b0;
        case (f3)
            3'd0:    data = (b >= 128) ? b - 32'd256 : b;
            3'd4:    data = b;
            3'd1:    data = (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    data = h;
            default: data = rdata;
        endcase
    endfunction

    // Drives one request and plays memory/consumer. Called at a negedge with the unit idle.
    // bad counts protocol violations: req_ready during the transaction, unstable araddr or
    // response, and a unit not idle after the response transfer.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic rerr,
                            input int ar_wait, input int r_wait, input int rsp_wait,
                            input bit junk,
                            output logic [31:0] data, output logic err, output bit saw_ar,
                            output logic [31:0] ar_addr, output int lat, output int n_rsp,
                            output int bad);
        int  k;
        int  ar_cnt;
        int  r_cnt;
        int  rsp_cnt;
        bit  done;
        saw_ar = 0; ar_addr = 0; data = 0; err = 0; lat = 0; n_rsp = 0; bad = 0;
        ar_cnt = 0; r_cnt = 0; rsp_cnt = 0; done = 0;
        req_valid  = 1'b1;
        req_addr   = addr;
        req_funct3 = f3;
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_funct3 = 3'($urandom);
        k = 1;
        while (!done && k < 60) begin
            if (req_ready) bad++;
            mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = '0;
            rsp_ready = 1'b0;
            if (mem_arvalid) begin
                if (saw_ar && mem_araddr !== ar_addr) bad++;
                saw_ar = 1;
                ar_addr = mem_araddr;
                mem_arready = (ar_cnt >= ar_wait);
                ar_cnt++;
            end else if (junk) begin
                mem_arready = 1'($urandom);
            end
            if (mem_rready) begin
                if (r_cnt >= r_wait) begin
                    mem_rvalid = 1'b1; mem_rdata = rdata; mem_rerr = rerr;
                end
                r_cnt++;
            end else if (junk) begin
                mem_rvalid = 1'($urandom); mem_rdata = $urandom; mem_rerr = 1'($urandom);
            end
            if (rsp_valid) begin
                if (rsp_cnt == 0) begin
                    data = rsp_data; err = rsp_err; lat = k; n_rsp++;
                end else if (rsp_data !== data || rsp_err !== err) begin
                    bad++;
                end
                if (rsp_cnt >= rsp_wait) begin
                    rsp_ready = 1'b1;
                    done = 1;
                end
                rsp_cnt++;
            end
            @(negedge clk);
            k++;
        end
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = '0;
        rsp_ready = 1'b0;
        if (!done) begin
            bad++;
            $display("FAIL timeout: no response transfer after %0d cycles (f3=%0d addr=0x%08h)",
                     k, f3, addr);
        end
        if (!req_ready || rsp_valid) bad++;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid) n_rsp++;
            @(negedge clk);
        end
    endtask

    logic [31:0] d;
    logic        e;
    bit          m;
    logic [31:0] aa;
    int          lat;
    int          nr;
    int          bad;
    logic [31:0] exp_d;
    logic        exp_e;
    bit          exp_m;
    int          cnt;

    initial begin
        rst = 1'b1;
        req_valid = 0; req_addr = 0; req_funct3 = 0;
        mem_arready = 0; mem_rvalid = 0; mem_rdata = 0; mem_rerr = 0; rsp_ready = 0;

        vecs[0]  = '{3'd0, 32'h0000_1003, 32'h80FF_1234, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b1};
        vecs[1]  = '{3'd5, 32'h0000_2002, 32'hBEEF_0001, 1'b0, 32'h0000_BEEF, 1'b0, 1'b1};
        vecs[2]  = '{3'd1, 32'h0000_2002, 32'hBEEF_0001, 1'b0, 32'hFFFF_BEEF, 1'b0, 1'b1};
        vecs[3]  = '{3'd3, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4]  = '{3'd2, 32'h0000_4000, 32'h1122_3344, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
`ifdef LOAD_MISALIGN_TRAP_EN
        vecs[5]  = '{3'd2, 32'h0000_3001, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[10] = '{3'd1, 32'h0000_0003, 32'h8001_7FFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
`else
        vecs[5]  = '{3'd2, 32'h0000_3001, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1};
        vecs[10] = '{3'd1, 32'h0000_0003, 32'h8001_7FFF, 1'b0, 32'hFFFF_8001, 1'b0, 1'b1};
`endif
        vecs[6]  = '{3'd4, 32'h0000_5001, 32'h80FF_1234, 1'b0, 32'h0000_0012, 1'b0, 1'b1};
        vecs[7]  = '{3'd0, 32'h0000_5002, 32'h80FF_1234, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vecs[8]  = '{3'd4, 32'h0000_5002, 32'h80FF_1234, 1'b0, 32'h0000_00FF, 1'b0, 1'b1};
        vecs[9]  = '{3'd1, 32'h0000_6000, 32'h1234_8765, 1'b0, 32'hFFFF_8765, 1'b0, 1'b1};
        vecs[11] = '{3'd7, 32'h0000_0008, 32'h5555_AAAA, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[12] = '{3'd2, 32'h0000_7004, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_ctrl_outputs", {27'd0, req_ready, mem_arvalid, mem_rready, rsp_valid,
                                     rsp_err}, 32'h0);
        check("reset_araddr", mem_araddr, 32'h0);
        check("reset_rsp_data", rsp_data, 32'h0);
        rst = 1'b0;
        #1;
        check("req_ready_after_reset", {31'd0, req_ready}, 32'h1);
        @(negedge clk);

        // Directed vectors, zero-wait memory
        foreach (vecs[i]) begin
            run_load(vecs[i].f3, vecs[i].addr, vecs[i].rdata, vecs[i].rerr, 0, 0, 0, 1'b0,
                     d, e, m, aa, lat, nr, bad);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_mem", i), {31'd0, m}, {31'd0, vecs[i].exp_mem});
            if (vecs[i].exp_mem) begin
                check($sformatf("vec%0d_araddr", i), aa, vecs[i].addr & 32'hFFFF_FFFC);
            end
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_mem ? 3 : 1);
            check($sformatf("vec%0d_nrsp", i), nr, 1);
            check($sformatf("vec%0d_protocol", i), bad, 0);
        end

        // Backpressure on every handshake
        run_load(3'd1, 32'h0000_2002, 32'h9ABC_5678, 1'b0, 4, 3, 5, 1'b1,
                 d, e, m, aa, lat, nr, bad);
        check("bp_data", d, 32'hFFFF_9ABC);
        check("bp_err", {31'd0, e}, 32'h0);
        check("bp_araddr", aa, 32'h0000_2000);
        check("bp_latency", lat, 10);
        check("bp_nrsp", nr, 1);
        check("bp_protocol", bad, 0);

        // Reset while in DATA, then a stray read beat
        req_valid = 1'b1; req_addr = 32'h0000_0100; req_funct3 = 3'd2;
        @(negedge clk);
        req_valid = 1'b0;
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0;
        check("midrst_in_data", {31'd0, mem_rready}, 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {27'd0, req_ready, mem_arvalid, mem_rready, rsp_valid,
                                 rsp_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777; mem_rerr = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid || !req_ready) cnt++;
            @(negedge clk);
        end
        check("midrst_no_response", cnt, 0);
        run_load(3'd2, 32'h0000_0200, 32'h0BAD_F00D, 1'b0, 0, 0, 0, 1'b0,
                 d, e, m, aa, lat, nr, bad);
        check("midrst_next_data", d, 32'h0BAD_F00D);
        check("midrst_next_err", {31'd0, e}, 32'h0);
        check("midrst_next_protocol", bad, 0);

        // Randomized transactions against the reference model
        for (int t = 0; t < 60; t++) begin
            logic [2:0]  rf3;
            logic [31:0] raddr;
            logic [31:0] rdat;
            logic        rerr;
            rf3   = 3'($urandom);
            raddr = $urandom;
            rdat  = $urandom;
            rerr  = ($urandom_range(0, 7) == 0);
            ref_load(rf3, raddr, rdat, rerr, exp_d, exp_e, exp_m);
            run_load(rf3, raddr, rdat, rerr, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'b1, d, e, m, aa, lat, nr, bad);
            check($sformatf("rnd%0d_data", t), d, exp_d);
            check($sformatf("rnd%0d_err", t), {31'd0, e}, {31'd0, exp_e});
            check($sformatf("rnd%0d_mem", t), {31'd0, m}, {31'd0, exp_m});
            if (exp_m) check($sformatf("rnd%0d_araddr", t), aa, {raddr[31:2], 2'b00});
            check($sformatf("rnd%0d_nrsp", t), nr, 1);
            check($sformatf("rnd%0d_protocol", t), bad, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have no parameters; the datapath is fixed at 32 bits (word_t).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  load request present.
REQ-005 req_ready  out  1  unit can accept a request.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes illegal.
REQ-008 mem_arvalid / mem_arready  out / in  1 / 1  memory read-address handshake.
REQ-009 mem_araddr  out  32  word-aligned address, {req_addr[31:2], 2'b00}.
REQ-010 mem_rvalid / mem_rready  in / out  1 / 1  memory read-data handshake.
REQ-011 mem_rdata  in  32  aligned read word; mem_rerr  in  1  bus error, qualified by mem_rvalid.
REQ-012 rsp_valid / rsp_ready  out / in  1 / 1  result handshake.
REQ-013 rsp_data  out  32  extended load result; rsp_err  out  1  load fault.

Function
REQ-014 FSM SHALL have states IDLE, ADDR, DATA, RESP; a transfer occurs only when valid and ready are both high in the same cycle.
REQ-015 IDLE: req_ready=1; on transfer, latch addr and funct3 and go to ADDR. Illegal funct3, or a misaligned access under REQ-024, goes to RESP instead, with rsp_err=1 and rsp_data=0.
REQ-016 ADDR: mem_arvalid=1 with mem_araddr stable until mem_arready; then go to DATA.
REQ-017 DATA: mem_rready=1; on mem_rvalid, register the result and go to RESP.
REQ-018 RESP: rsp_valid=1; rsp_data and rsp_err stay stable until rsp_ready; then go to IDLE; req_ready=0 in RESP (no overlap).
REQ-019 Minimum latency SHALL be 3 cycles: request accepted in cycle N, arvalid in N+1, rready in N+2, rsp_valid in N+3, given zero-wait memory.
REQ-020 Lane select: byte = mem_rdata[8*a+7:8*a] with a=addr[1:0]; half = mem_rdata[16*h+15:16*h] with h=addr[1].
REQ-021 LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-022 mem_rerr=1 on the data beat SHALL give rsp_err=1, rsp_data=0.
REQ-023 mem_rvalid outside DATA and mem_arready outside ADDR SHALL be ignored.

Configuration
REQ-024 Macro LOAD_MISALIGN_TRAP_EN defined: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, SHALL be answered with rsp_err=1, rsp_data=0, and no memory transaction.
REQ-025 Macro undefined: no misalignment check; LW ignores addr[1:0]; LH/LHU ignore addr[0]; the memory access proceeds normally.

Reset
REQ-026 While rst=1, state=IDLE and all outputs SHALL be 0, including req_ready; the first cycle after deassertion has req_ready=1.
REQ-027 Reset mid-operation SHALL abandon the transaction with no response; a late mem_rvalid afterwards is ignored per REQ-023.

Verification
REQ-028 LB addr=0x1003, rdata=0x80FF_1234, zero-wait memory -> araddr=0x1000, rsp_data=0xFFFF_FF80, rsp_err=0, rsp_valid 3 cycles after accept.
REQ-029 LHU addr=0x2002, rdata=0xBEEF_0001 -> rsp_data=0x0000_BEEF; same with LH -> 0xFFFF_BEEF.
REQ-030 funct3=011, addr=0x0 -> no mem_arvalid, rsp_err=1, rsp_data=0; mem_rerr=1 on an LW -> rsp_err=1, rsp_data=0.
REQ-031 LW addr=0x3001: with LOAD_MISALIGN_TRAP_EN -> no mem access, rsp_err=1; without -> araddr=0x3000, rsp_data=rdata.
REQ-032 Backpressure: arready low 4 cycles, rvalid delayed 3 cycles, rsp_ready low 5 cycles -> araddr and rsp_data stable throughout, exactly one response, req_ready=0 until the response transfer completes.
REQ-033 Assert rst in DATA, then pulse mem_rvalid after release -> no rsp_valid, req_ready=1, next LW completes correctly.
